// File: rtl/cop_ise_mc_if.sv
// rtl/cop_ise_mc_if.sv - co-processor port bundle between RV32 host and Jambu ISE adapter
interface cop_ise_mc_if;
  logic        cop_valid;
  logic        cop_rdywr;
  logic        cop_ready;
  logic        cop_wait;
  logic        cop_wr;
  logic [31:0] cop_insn;
  logic [31:0] cop_rs1;
  logic [31:0] cop_rs2;
  logic [31:0] cop_rd;

  modport master (
    output cop_valid, cop_rdywr, cop_insn, cop_rs1, cop_rs2,
    input  cop_ready, cop_wait, cop_wr, cop_rd
  );

  modport slave (
    input  cop_valid, cop_rdywr, cop_insn, cop_rs1, cop_rs2,
    output cop_ready, cop_wait, cop_wr, cop_rd
  );
endinterface

// File: rtl/cop_ise_mc.sv
// rtl/cop_ise_mc.sv - multi-cycle Jambu funnel-shift co-processor adapter
module cop_ise_mc #(
  parameter logic [2:0] ISE_V = 3'b111,
  parameter int         LAT   = 1
) (
  input  logic         cop_clk,
  input  logic         cop_rst,
  cop_ise_mc_if.slave  cop
);

  if (LAT < 1 || LAT > 8) begin : g_bad_lat
    $error("cop_ise_mc: LAT must be in 1..8");
  end

  localparam logic [2:0] CNT_INIT = (LAT > 1) ? 3'(LAT - 2) : 3'd0;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [31:0] rs1_q;
  logic [31:0] rs2_q;
  logic [4:0]  sh_q;
  logic        wait_q;
  logic        wr_q;

  logic [6:0]  funct;
  logic [6:0]  opc;
  logic        fsri_hit;
  logic        fsr_hit;
  logic        hit;
  logic [4:0]  sh_dec;
  logic        ready;
  logic        acc;
  logic [31:0] result;

  assign funct    = cop.cop_insn[31:25];
  assign opc      = cop.cop_insn[6:0];
  assign fsri_hit = ISE_V[1] && (opc == 7'b0101011) && (funct[6:5] == 2'b00);
  assign fsr_hit  = ISE_V[2] && (opc == 7'b1111011) && (funct[6:2] == 5'd0);
  assign hit      = fsri_hit | fsr_hit;

  always_comb begin
    sh_dec = funct[4:0];
    if (fsr_hit) begin
      case (funct[1:0])
        2'd0:    sh_dec = 5'd15;
        2'd1:    sh_dec = 5'd6;
        2'd2:    sh_dec = 5'd21;
        default: sh_dec = 5'd27;
      endcase
    end
  end

  // RESP frees the slot in the same cycle the host takes the write-back.
  assign ready = (state == IDLE) || ((state == RESP) && cop.cop_rdywr);
  assign acc   = cop.cop_valid && ready && hit;

  assign result = 32'({rs2_q, rs1_q} >> sh_q);

  assign cop.cop_ready = ready;
  assign cop.cop_wait  = wait_q;
  assign cop.cop_wr    = wr_q;
  assign cop.cop_rd    = wr_q ? result : 32'd0;

  always_ff @(posedge cop_clk) begin
    if (cop_rst) begin
      state  <= IDLE;
      cnt    <= 3'd0;
      rs1_q  <= 32'd0;
      rs2_q  <= 32'd0;
      sh_q   <= 5'd0;
      wait_q <= 1'b0;
      wr_q   <= 1'b0;
    end else if (acc) begin
      rs1_q <= cop.cop_rs1;
      rs2_q <= cop.cop_rs2;
      sh_q  <= sh_dec;
      if (LAT == 1) begin
        state  <= RESP;
        wait_q <= 1'b0;
        wr_q   <= 1'b1;
      end else begin
        state  <= EXEC;
        cnt    <= CNT_INIT;
        wait_q <= 1'b1;
        wr_q   <= 1'b0;
      end
    end else begin
      case (state)
        EXEC: begin
          if (cnt == 3'd0) begin
            state  <= RESP;
            wait_q <= 1'b0;
            wr_q   <= 1'b1;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          if (cop.cop_rdywr) begin
            state <= IDLE;
            wr_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cop_ise_mc.sv
// tb/tb_cop_ise_mc.sv - bench for cop_ise_mc: three configurations on shared stimulus, cycle model
module tb_cop_ise_mc;

  localparam int LATS [3] = '{1, 4, 1};
  localparam int ISEV [3] = '{7, 7, 2};
  localparam logic [31:0] A = 32'h89ABCDEF;
  localparam logic [31:0] B = 32'h01234567;

  logic        clk;
  logic        rst;
  logic        valid;
  logic        rdywr;
  logic [31:0] insn;
  logic [31:0] rs1;
  logic [31:0] rs2;

  cop_ise_mc_if if1 ();
  cop_ise_mc_if if4 ();
  cop_ise_mc_if ifv ();

  assign if1.cop_valid = valid;  assign if4.cop_valid = valid;  assign ifv.cop_valid = valid;
  assign if1.cop_rdywr = rdywr;  assign if4.cop_rdywr = rdywr;  assign ifv.cop_rdywr = rdywr;
  assign if1.cop_insn  = insn;   assign if4.cop_insn  = insn;   assign ifv.cop_insn  = insn;
  assign if1.cop_rs1   = rs1;    assign if4.cop_rs1   = rs1;    assign ifv.cop_rs1   = rs1;
  assign if1.cop_rs2   = rs2;    assign if4.cop_rs2   = rs2;    assign ifv.cop_rs2   = rs2;

  cop_ise_mc #(.ISE_V(3'b111), .LAT(1)) u1 (.cop_clk(clk), .cop_rst(rst), .cop(if1));
  cop_ise_mc #(.ISE_V(3'b111), .LAT(4)) u4 (.cop_clk(clk), .cop_rst(rst), .cop(if4));
  cop_ise_mc #(.ISE_V(3'b010), .LAT(1)) uv (.cop_clk(clk), .cop_rst(rst), .cop(ifv));

  logic [2:0]  o_ready, o_wait, o_wr;
  logic [31:0] o_rd [3];
  assign o_ready = {ifv.cop_ready, if4.cop_ready, if1.cop_ready};
  assign o_wait  = {ifv.cop_wait,  if4.cop_wait,  if1.cop_wait};
  assign o_wr    = {ifv.cop_wr,    if4.cop_wr,    if1.cop_wr};
  assign o_rd[0] = if1.cop_rd;
  assign o_rd[1] = if4.cop_rd;
  assign o_rd[2] = ifv.cop_rd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: one outstanding job per config, result due LAT cycles after acceptance.
  int          cyc;
  logic        m_busy [3];
  int          m_due  [3];
  logic [31:0] m_res  [3];

  function automatic void ref_dec(input logic [31:0] w, input int isev,
                                  output logic h, output int sh);
    int fn, op;
    int tab [4] = '{15, 6, 21, 27};
    fn = int'(w >> 25);
    op = int'(w & 32'h7F);
    h  = 1'b0;
    sh = 0;
    if (op == 'h2B && fn < 32 && (isev & 2) != 0) begin
      h = 1'b1; sh = fn;
    end else if (op == 'h7B && fn < 4 && (isev & 4) != 0) begin
      h = 1'b1; sh = tab[fn];
    end
  endfunction

  function automatic logic [31:0] funnel(input logic [31:0] lo, input logic [31:0] hi, input int sh);
    logic [63:0] cat;
    cat = {hi, lo};
    cat = cat >> sh;
    return cat[31:0];
  endfunction

  task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] a,
                       input logic [31:0] b, input logic rdy, input logic r);
    logic e_ready, e_wait, e_wr, h;
    logic [31:0] e_rd;
    int sh;
    @(negedge clk);
    valid = v; insn = w; rs1 = a; rs2 = b; rdywr = rdy; rst = r;
    #1;
    for (int d = 0; d < 3; d++) begin
      e_ready = 1'b1; e_wait = 1'b0; e_wr = 1'b0; e_rd = 32'd0;
      if (m_busy[d] && cyc >= m_due[d]) begin
        e_wr = 1'b1; e_rd = m_res[d]; e_ready = rdy;
      end else if (m_busy[d]) begin
        e_ready = 1'b0; e_wait = 1'b1;
      end
      chk($sformatf("c%0d cyc%0d ready", d, cyc), 32'(o_ready[d]), 32'(e_ready));
      chk($sformatf("c%0d cyc%0d wait", d, cyc),  32'(o_wait[d]),  32'(e_wait));
      chk($sformatf("c%0d cyc%0d wr", d, cyc),    32'(o_wr[d]),    32'(e_wr));
      chk($sformatf("c%0d cyc%0d rd", d, cyc),    o_rd[d],         e_rd);
      ref_dec(w, ISEV[d], h, sh);
      if (r) begin
        m_busy[d] = 1'b0;
      end else begin
        if (e_wr && rdy) m_busy[d] = 1'b0;
        if (v && e_ready && h) begin
          m_busy[d] = 1'b1;
          m_due[d]  = cyc + LATS[d];
          m_res[d]  = funnel(a, b, sh);
        end
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
  endtask

  typedef struct {
    logic [31:0] w;
    logic [31:0] a;
    logic [31:0] b;
    logic        hit;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl [12];

  initial begin
    tbl = '{
      '{(32'd8  << 25) | 32'h2B, A, B, 1'b1, 32'h6789ABCD},
      '{32'h2B,                  A, B, 1'b1, 32'h89ABCDEF},
      '{(32'd1  << 25) | 32'h2B, A, B, 1'b1, 32'hC4D5E6F7},
      '{(32'd31 << 25) | 32'h2B, A, B, 1'b1, 32'h02468ACF},
      '{(32'd16 << 25) | 32'h2B, A, B, 1'b1, 32'h456789AB},
      '{32'h7B,                  A, B, 1'b1, 32'h8ACF1357},
      '{(32'd1  << 25) | 32'h7B, A, B, 1'b1, 32'h9E26AF37},
      '{(32'd2  << 25) | 32'h7B, 32'hFFFFFFFF, 32'd0, 1'b1, 32'h000007FF},
      '{(32'd3  << 25) | 32'h7B, 32'd0, 32'd1, 1'b1, 32'h00000020},
      '{(32'd32 << 25) | 32'h2B, A, B, 1'b0, 32'd0},
      '{(32'd4  << 25) | 32'h7B, A, B, 1'b0, 32'd0},
      '{(32'd8  << 25) | 32'h0B, A, B, 1'b0, 32'd0}
    };

    rst = 1'b1; valid = 1'b0; rdywr = 1'b1; insn = '0; rs1 = '0; rs2 = '0;
    cyc = 0;
    for (int d = 0; d < 3; d++) begin
      m_busy[d] = 1'b0; m_due[d] = 0; m_res[d] = '0;
    end
    repeat (3) @(posedge clk);

    idle(1);
    chk("reset ready", 32'(if1.cop_ready), 32'd1);
    chk("reset wait",  32'(if1.cop_wait),  32'd0);
    chk("reset wr",    32'(if1.cop_wr),    32'd0);
    chk("reset rd",    if1.cop_rd,         32'd0);
    idle(5);

    // Decode and funnel-shift vectors on the LAT=1 full-ISE instance
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, tbl[i].w, tbl[i].a, tbl[i].b, 1'b1, 1'b0);
      chk($sformatf("vec%0d ready", i), 32'(if1.cop_ready), 32'd1);
      drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      chk($sformatf("vec%0d wr", i), 32'(if1.cop_wr), 32'(tbl[i].hit));
      chk($sformatf("vec%0d rd", i), if1.cop_rd, tbl[i].rd);
    end
    idle(6);

    // LAT=4 latency and wait window
    drive(1'b1, 32'h7B, A, B, 1'b1, 1'b0);
    chk("lat4 accept ready", 32'(if4.cop_ready), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      chk($sformatf("lat4 t+%0d wait", k), 32'(if4.cop_wait), 32'd1);
      chk($sformatf("lat4 t+%0d wr", k),   32'(if4.cop_wr),   32'd0);
    end
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("lat4 t+4 wr", 32'(if4.cop_wr), 32'd1);
    chk("lat4 t+4 rd", if4.cop_rd, 32'h8ACF1357);
    idle(6);

    // Write-back back-pressure with changing operands
    drive(1'b1, (32'd8 << 25) | 32'h2B, A, B, 1'b1, 1'b0);
    idle(3);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, (32'd3 << 25) | 32'h2B, $urandom, $urandom, 1'b0, 1'b0);
      chk($sformatf("bp%0d wr", k),    32'(if4.cop_wr),    32'd1);
      chk($sformatf("bp%0d rd", k),    if4.cop_rd,         32'h6789ABCD);
      chk($sformatf("bp%0d ready", k), 32'(if4.cop_ready), 32'd0);
    end
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("bp retire wr", 32'(if4.cop_wr), 32'd1);
    chk("bp retire rd", if4.cop_rd, 32'h6789ABCD);
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("bp after wr", 32'(if4.cop_wr), 32'd0);
    idle(6);

    // Back-to-back issue at LAT=1
    begin
      logic [31:0] shs [4] = '{32'd0, 32'd1, 32'd31, 32'd16};
      logic [31:0] exp [4] = '{32'h89ABCDEF, 32'hC4D5E6F7, 32'h02468ACF, 32'h456789AB};
      for (int k = 0; k < 5; k++) begin
        if (k < 4) drive(1'b1, (shs[k] << 25) | 32'h2B, A, B, 1'b1, 1'b0);
        else       drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        if (k > 0) begin
          chk($sformatf("b2b%0d wr", k), 32'(if1.cop_wr), 32'd1);
          chk($sformatf("b2b%0d rd", k), if1.cop_rd, exp[k-1]);
        end
      end
    end
    idle(6);

    // Disabled group and foreign opcode on ISE_V=010
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, (k < 2) ? 32'h7B : ((32'd5 << 25) | 32'h0B), A, B, 1'b1, 1'b0);
      chk($sformatf("isev%0d ready", k), 32'(ifv.cop_ready), 32'd1);
      chk($sformatf("isev%0d wr", k),    32'(ifv.cop_wr),    32'd0);
    end
    idle(6);

    // Reset while executing discards the result
    drive(1'b1, (32'd8 << 25) | 32'h2B, A, B, 1'b1, 1'b0);
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    chk("rst t+2 wait", 32'(if4.cop_wait), 32'd1);
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("rst t+3 ready", 32'(if4.cop_ready), 32'd1);
    chk("rst t+3 wait",  32'(if4.cop_wait),  32'd0);
    for (int k = 4; k <= 8; k++) begin
      drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      chk($sformatf("rst t+%0d wr", k), 32'(if4.cop_wr), 32'd0);
    end
    drive(1'b1, 32'h7B, A, B, 1'b1, 1'b0);
    idle(3);
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("post-rst wr", 32'(if4.cop_wr), 32'd1);
    chk("post-rst rd", if4.cop_rd, 32'h8ACF1357);

    // Randomised traffic against the cycle model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] w;
      case ($urandom_range(0, 3))
        0:       w = {7'($urandom_range(0, 40)), 18'($urandom), 7'h2B};
        1:       w = {7'($urandom_range(0, 5)),  18'($urandom), 7'h7B};
        2:       w = {7'($urandom_range(0, 31)), 18'($urandom), 7'h0B};
        default: w = $urandom;
      endcase
      drive($urandom_range(0, 3) != 0, w, $urandom, $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
